scale_frac_div_iter: RTL and testbench

- Parametrised successor to the fixed-width posit scale/fraction divider.
- Takes two decoded posit operands (signed scale plus unsigned <1.F> fraction with hidden bit), subtracts the scales, and divides the fractions with a multi-cycle radix-2 restoring divider.
- Uses a valid/ready handshake, flags divide-by-zero, and produces a sticky remainder bit for the downstream rounding/encode stage.
- Trades the unrolled pipeline for one shared subtractor, cutting area for low-throughput posit cores.

---
 rtl/scale_frac_div_pkg.sv | 37 +++
 rtl/scale_frac_div_iter_step.sv | 27 ++
 rtl/scale_frac_div_iter.sv | 158 +++++++++++++++
 tb/tb_scale_frac_div_iter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/scale_frac_div_pkg.sv
// Shared definitions for the iterative posit scale/fraction divider.
//
// Contents:
//   state_t      - divider control states (IDLE, DIV, DONE)
//   QUOT_BITS_DEF- default quotient fraction width
//   div_iters()  - number of restoring iterations for a given QUOT_BITS
//   cnt_width()  - iteration counter width for a given QUOT_BITS
//
// Optional feature macro: SCALE_FRAC_DIV_NORM_EN
//   When defined, one extra quotient bit is produced so the result can be
//   normalised to <1.QUOT_BITS> with the hidden bit always set.
package scale_frac_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    localparam int QUOT_BITS_DEF = 10;

    // Raw quotient length: QUOT_BITS+1 bits, plus one guard bit that the
    // normaliser may shift in when the quotient falls below 1.0.
    function automatic int div_iters(input int quot_bits);
`ifdef SCALE_FRAC_DIV_NORM_EN
        return quot_bits + 2;
`else
        return quot_bits + 1;
`endif
    endfunction

    // Sized for the longest build so both variants share one counter width.
    function automatic int cnt_width(input int quot_bits);
        return $clog2(quot_bits + 2);
    endfunction

endpackage

// File: rtl/scale_frac_div_iter_step.sv
// One radix-2 restoring division step (also intended for the sqrt unit).
//
// Ports:
//   r      in  W  partial remainder
//   b      in  W  divisor, zero-extended to W
//   r_next out W  (r >= b ? r - b : r) << 1
//   q      out 1  quotient bit for this step
module div_restore_step #(
    parameter int W = 7
) (
    input  logic [W-1:0] r,
    input  logic [W-1:0] b,
    output logic [W-1:0] r_next,
    output logic         q
);

    logic [W-1:0] r_sub;

    // Remainder stays below b after the subtract, so the shift never
    // drops a set bit.
    always_comb begin
        q      = (r >= b);
        r_sub  = q ? (r - b) : r;
        r_next = r_sub << 1;
    end

endmodule

// File: rtl/scale_frac_div_iter.sv
// Iterative posit scale/fraction divider.
//
// Subtracts signed scales and divides <1.FRAC_W-1> fractions one quotient
// bit per cycle through a single shared restoring step. Result is held in
// DONE until the consumer accepts it.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   IN_VALID/IN_READY   operand handshake (ready only in IDLE)
//   SCALE_A, SCALE_B    signed scales, SCALE_W bits
//   FRAC_A, FRAC_B      fractions with hidden MSB, FRAC_W bits
//   OUT_VALID/OUT_READY result handshake
//   SCALE_C             SCALE_A - SCALE_B, SCALE_W+1 bits
//   FRAC_C              truncated quotient <1.QUOT_BITS>
//   REM_C               sticky bit of discarded quotient/remainder bits
//   DIVZ_C              divisor hidden bit was 0
//
// Optional feature macro: SCALE_FRAC_DIV_NORM_EN (normalised quotient).
module scale_frac_div_iter
    import scale_frac_div_pkg::*;
#(
    parameter int SCALE_W   = 4,
    parameter int FRAC_W    = 6,
    parameter int QUOT_BITS = QUOT_BITS_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [SCALE_W-1:0]   SCALE_A,
    input  logic [SCALE_W-1:0]   SCALE_B,
    input  logic [FRAC_W-1:0]    FRAC_A,
    input  logic [FRAC_W-1:0]    FRAC_B,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [SCALE_W:0]     SCALE_C,
    output logic [QUOT_BITS:0]   FRAC_C,
    output logic                 REM_C,
    output logic                 DIVZ_C
);

    localparam int N     = div_iters(QUOT_BITS);
    localparam int CNT_W = cnt_width(QUOT_BITS);
    localparam int RW    = FRAC_W + 1;
    localparam int SW    = SCALE_W + 1;
    localparam int FW    = QUOT_BITS + 1;

    state_t           state, state_nx;
    logic [RW-1:0]    r_reg, b_reg, r_next;
    logic [N-2:0]     q_reg;
    logic [N-1:0]     q_full;
    logic             q_bit;
    logic [SW-1:0]    diff_in, diff_reg;
    logic [CNT_W-1:0] cnt;
    logic             accept, divz_in;
    logic [FW-1:0]    frac_fin;
    logic [SW-1:0]    scale_fin;
    logic             rem_fin;

    assign accept  = IN_VALID & IN_READY;
    assign divz_in = ~FRAC_B[FRAC_W-1];
    assign diff_in = {SCALE_A[SCALE_W-1], SCALE_A} - {SCALE_B[SCALE_W-1], SCALE_B};

    div_restore_step #(.W(RW)) u_step (
        .r      (r_reg),
        .b      (b_reg),
        .r_next (r_next),
        .q      (q_bit)
    );

    // Quotient including the bit produced this cycle; on the last DIV
    // cycle this is the complete raw quotient.
    assign q_full = {q_reg, q_bit};

`ifdef SCALE_FRAC_DIV_NORM_EN
    always_comb begin
        if (q_full[N-1]) begin
            frac_fin  = q_full[N-1:1];
            scale_fin = diff_reg;
            rem_fin   = q_full[0] | (|r_next);
        end else begin
            frac_fin  = q_full[QUOT_BITS:0];
            scale_fin = diff_reg - SW'(1);
            rem_fin   = |r_next;
        end
    end
`else
    always_comb begin
        frac_fin  = q_full;
        scale_fin = diff_reg;
        rem_fin   = |r_next;
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        case (state)
            IDLE: begin
                IN_READY = ~RST;
                if (IN_VALID && !RST) state_nx = divz_in ? DONE : DIV;
            end
            DIV: begin
                if (cnt == '0) state_nx = DONE;
            end
            DONE: begin
                OUT_VALID = ~RST;
                if (OUT_READY) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_reg    <= '0;
            b_reg    <= '0;
            q_reg    <= '0;
            diff_reg <= '0;
            cnt      <= '0;
            SCALE_C  <= '0;
            FRAC_C   <= '0;
            REM_C    <= 1'b0;
            DIVZ_C   <= 1'b0;
        end else if (accept) begin
            r_reg    <= {1'b0, FRAC_A};
            b_reg    <= {1'b0, FRAC_B};
            q_reg    <= '0;
            diff_reg <= diff_in;
            cnt      <= CNT_W'(N - 1);
            // Zero divisor skips the iterations and publishes directly.
            if (divz_in) begin
                SCALE_C <= diff_in;
                FRAC_C  <= '0;
                REM_C   <= 1'b0;
                DIVZ_C  <= 1'b1;
            end
        end else if (state == DIV) begin
            r_reg <= r_next;
            q_reg <= q_full[N-2:0];
            if (cnt == '0) begin
                SCALE_C <= scale_fin;
                FRAC_C  <= frac_fin;
                REM_C   <= rem_fin;
                DIVZ_C  <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scale_frac_div_iter.sv
// Self-checking bench for scale_frac_div_iter (default parameters).
// Table vectors are driven one at a time; expected results go into a
// scoreboard queue at drive time and are popped by a monitor when the
// DUT hands a result over. Hand sequences cover backpressure and reset.
module tb_scale_frac_div_iter;

`ifdef SCALE_FRAC_DIV_NORM_EN
    localparam int NITER = 12;
`else
    localparam int NITER = 11;
`endif

    typedef struct {
        int sa, sb, a, b;
        int scale, frac, rem, divz;
    } vec_t;

    typedef struct {
        int scale, frac, rem, divz;
    } exp_t;

    logic       CLK, RST, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
    logic [3:0] SCALE_A, SCALE_B;
    logic [5:0] FRAC_A, FRAC_B;
    logic [4:0] SCALE_C;
    logic [10:0] FRAC_C;
    logic       REM_C, DIVZ_C;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    vec_t tbl[10];

    scale_frac_div_iter dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .SCALE_A(SCALE_A), .SCALE_B(SCALE_B),
        .FRAC_A(FRAC_A), .FRAC_B(FRAC_B),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .SCALE_C(SCALE_C), .FRAC_C(FRAC_C),
        .REM_C(REM_C), .DIVZ_C(DIVZ_C)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a result is consumed when valid and ready meet.
    always @(negedge CLK) begin
        if (!RST && OUT_VALID && OUT_READY) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got frac %0d, expected none", FRAC_C);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("scale_c", int'($signed(SCALE_C)), e.scale);
                chk("frac_c",  int'(FRAC_C), e.frac);
                chk("rem_c",   int'(REM_C),  e.rem);
                chk("divz_c",  int'(DIVZ_C), e.divz);
            end
        end
    end

    // Drive one operand pair from IDLE and wait for the result to appear.
    // Latency counts the accept edge as the first cycle.
    task automatic do_op(input vec_t v);
        int   cnt;
        exp_t e;
        chk("in_ready_idle", int'(IN_READY), 1);
        SCALE_A  = 4'(v.sa);
        SCALE_B  = 4'(v.sb);
        FRAC_A   = 6'(v.a);
        FRAC_B   = 6'(v.b);
        IN_VALID = 1'b1;
        e = '{v.scale, v.frac, v.rem, v.divz};
        sb_q.push_back(e);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        cnt = 1;
        while (!OUT_VALID && cnt < 100) begin
            @(posedge CLK); #1;
            cnt++;
        end
        chk("latency", cnt, (v.divz != 0) ? 1 : NITER + 1);
        chk("in_ready_done", int'(IN_READY), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int highs;
        //           sa  sb   a   b  scale frac rem divz
`ifdef SCALE_FRAC_DIV_NORM_EN
        tbl[0] = '{  3,  1, 32, 32,   2, 1024, 0, 0};
        tbl[1] = '{  0,  0, 32, 48,  -1, 1365, 1, 0};
        tbl[2] = '{  7, -8, 32, 32,  15, 1024, 0, 0};
        tbl[3] = '{ -8,  7, 32, 48, -16, 1365, 1, 0};
        tbl[4] = '{  2, -3, 40,  0,   5,    0, 0, 1};
        tbl[5] = '{  1, -1, 63, 32,   2, 2016, 0, 0};
        tbl[6] = '{  0,  2, 32, 63,  -3, 1040, 1, 0};
        tbl[7] = '{  1,  1,  0, 40,  -1,    0, 0, 0};
        tbl[8] = '{ -2,  3, 45, 37,  -5, 1245, 1, 0};
        tbl[9] = '{ -4, -4, 63, 31,   0,    0, 0, 1};
`else
        tbl[0] = '{  3,  1, 32, 32,   2, 1024, 0, 0};
        tbl[1] = '{  0,  0, 32, 48,   0,  682, 1, 0};
        tbl[2] = '{  7, -8, 32, 32,  15, 1024, 0, 0};
        tbl[3] = '{ -8,  7, 32, 48, -15,  682, 1, 0};
        tbl[4] = '{  2, -3, 40,  0,   5,    0, 0, 1};
        tbl[5] = '{  1, -1, 63, 32,   2, 2016, 0, 0};
        tbl[6] = '{  0,  2, 32, 63,  -2,  520, 1, 0};
        tbl[7] = '{  1,  1,  0, 40,   0,    0, 0, 0};
        tbl[8] = '{ -2,  3, 45, 37,  -5, 1245, 1, 0};
        tbl[9] = '{ -4, -4, 63, 31,   0,    0, 0, 1};
`endif

        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
        SCALE_A = '0; SCALE_B = '0; FRAC_A = '0; FRAC_B = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_out_valid", int'(OUT_VALID), 0);
        chk("rst_in_ready",  int'(IN_READY), 0);
        chk("rst_scale_c",   int'(SCALE_C), 0);
        chk("rst_frac_c",    int'(FRAC_C), 0);
        chk("rst_rem_c",     int'(REM_C), 0);
        chk("rst_divz_c",    int'(DIVZ_C), 0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Table vectors with OUT_READY held high: one-cycle valid each.
        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i]);
            @(posedge CLK); #1;
            chk("valid_one_cycle", int'(OUT_VALID), 0);
        end

        // Backpressure: hold the result, offer a second operand meanwhile.
        OUT_READY = 1'b0;
        do_op(tbl[0]);
        SCALE_A = 4'(-2); SCALE_B = 4'(3); FRAC_A = 6'(45); FRAC_B = 6'(37);
        IN_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            chk("bp_out_valid", int'(OUT_VALID), 1);
            chk("bp_in_ready",  int'(IN_READY), 0);
            chk("bp_frac_c",    int'(FRAC_C), tbl[0].frac);
            chk("bp_scale_c",   int'($signed(SCALE_C)), tbl[0].scale);
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        chk("bp_release_valid", int'(OUT_VALID), 0);
        chk("bp_release_ready", int'(IN_READY), 1);
        highs = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge CLK); #1;
            if (OUT_VALID) highs++;
        end
        chk("bp_ignored_op", highs, 0);

        // Reset in the middle of an iteration.
        SCALE_A = 4'(0); SCALE_B = 4'(0); FRAC_A = 6'(32); FRAC_B = 6'(48);
        IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        chk("middiv_busy", int'(IN_READY), 0);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("middiv_rst_valid", int'(OUT_VALID), 0);
        chk("middiv_rst_ready", int'(IN_READY), 0);
        chk("middiv_rst_frac",  int'(FRAC_C), 0);
        chk("middiv_rst_scale", int'(SCALE_C), 0);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("middiv_ready_after", int'(IN_READY), 1);
        highs = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge CLK); #1;
            if (OUT_VALID) highs++;
        end
        chk("middiv_no_output", highs, 0);

        // Block still works after the aborted operation.
        do_op(tbl[8]);
        @(posedge CLK); #1;
        repeat (2) @(posedge CLK);
        #1;
        chk("queue_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
